mem_stage_ctrl: RTL and testbench

Memory-stage controller sitting between the EX/MEM pipeline register and the MEM/WB boundary. It consumes the EX/MEM register outputs and runs a req/ack handshake to a variable-latency data memory. It stalls upstream stages while an access is outstanding and drives registered MEM/WB outputs, inserting bubbles where needed.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_wait_cnt.sv | 31 +++
 rtl/mem_stage_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-stage controller.
// Contents: FSM state constants, control-bit indices and widths, and the
// packed structs used for the latched memory command and the MEM/WB slot.
package mem_stage_pkg;
  localparam int CTRL_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_cmd_t;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       rdata;
    logic [31:0]       alu;
    logic [4:0]        wreg;
    logic              err;
  } wb_slot_t;
endpackage

// File: rtl/mem_wait_cnt.sv
// Wait-cycle counter for the memory handshake.
// Ports: clk, rst (async active-low), clr_i (synchronous clear, wins over
// en_i), en_i (count up), hit_o (counter sits at TIMEOUT-1; never set when
// TIMEOUT==0).
module mem_wait_cnt #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign hit_o = (TIMEOUT != 0) && (cnt_q == LAST);
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between EX/MEM and MEM/WB.
// Runs a registered req / one-cycle-ack handshake to a variable-latency data
// memory, stalls upstream while an access is outstanding, and produces
// registered MEM/WB outputs (bubble while waiting, bus_err on abort).
// Ports: clk, rst (async active-low); EX/MEM side in_valid, MEM_WB, MEM_M,
// MEM_ALU_out, DM_Wdata, MEM_writeReg; stall to upstream; memory side dm_req,
// dm_we, dm_addr, dm_wdata, dm_rdata, dm_ack; MEM/WB side wb_valid, WB_ctrl,
// WB_rdata, WB_alu, WB_writeReg, bus_err.
// Optional: define MEM_ALIGN_CHK_EN to turn misaligned memops into an
// immediate bus error instead of a memory access.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] MEM_WB,
  input  logic [CTRL_W-1:0] MEM_M,
  input  logic [31:0]       MEM_ALU_out,
  input  logic [31:0]       DM_Wdata,
  input  logic [4:0]        MEM_writeReg,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] WB_ctrl,
  output logic [31:0]       WB_rdata,
  output logic [31:0]       WB_alu,
  output logic [4:0]        WB_writeReg,
  output logic              bus_err
);
  logic [0:0] state_q, state_d;
  logic       req_q, req_d;
  dm_cmd_t    cmd_q, cmd_d;
  wb_slot_t   wb_q, wb_d;

  logic in_wait, memop, misalign, cnt_hit, timeout_hit;

  assign in_wait = (state_q == ST_WAIT);
  assign memop   = in_valid & (MEM_M[M_MEMREAD] | MEM_M[M_MEMWRITE]);
`ifdef MEM_ALIGN_CHK_EN
  assign misalign = memop & (|MEM_ALU_out[1:0]);
`else
  assign misalign = 1'b0;
`endif

  mem_wait_cnt #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~in_wait),
    .en_i  (in_wait),
    .hit_o (cnt_hit)
  );

  // A late ack on the last allowed cycle still completes normally.
  assign timeout_hit = in_wait & cnt_hit & ~dm_ack;
  // Combinational so EX/MEM advances on the very edge the access retires.
  assign stall = (~in_wait & memop & ~misalign) | (in_wait & ~dm_ack & ~timeout_hit);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    wb_d    = wb_q;
    if (!in_wait) begin
      wb_d.alu  = MEM_ALU_out;
      wb_d.wreg = MEM_writeReg;
      wb_d.ctrl = MEM_WB;
      wb_d.rdata = '0;
      wb_d.err   = 1'b0;
      if (!in_valid) begin
        wb_d.valid = 1'b0;
        wb_d.ctrl  = '0;
      end else if (misalign) begin
        wb_d.valid             = 1'b1;
        wb_d.err               = 1'b1;
        wb_d.ctrl[WB_REGWRITE] = 1'b0;
      end else if (memop) begin
        // Both MemRead and MemWrite set is treated as a store.
        cmd_d.we    = MEM_M[M_MEMWRITE];
        cmd_d.addr  = MEM_ALU_out;
        cmd_d.wdata = DM_Wdata;
        req_d       = 1'b1;
        wb_d.valid  = 1'b0;
        state_d     = ST_WAIT;
      end else begin
        wb_d.valid = 1'b1;
      end
    end else if (dm_ack) begin
      req_d      = 1'b0;
      wb_d.valid = 1'b1;
      wb_d.err   = 1'b0;
      wb_d.rdata = cmd_q.we ? 32'h0 : dm_rdata;
      state_d    = ST_IDLE;
    end else if (timeout_hit) begin
      req_d                  = 1'b0;
      wb_d.valid             = 1'b1;
      wb_d.err               = 1'b1;
      wb_d.rdata             = '0;
      wb_d.ctrl[WB_REGWRITE] = 1'b0;
      state_d                = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      cmd_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      wb_q    <= wb_d;
    end
  end

  assign dm_req      = req_q;
  assign dm_we       = cmd_q.we;
  assign dm_addr     = cmd_q.addr;
  assign dm_wdata    = cmd_q.wdata;
  assign wb_valid    = wb_q.valid;
  assign WB_ctrl     = wb_q.ctrl;
  assign WB_rdata    = wb_q.rdata;
  assign WB_alu      = wb_q.alu;
  assign WB_writeReg = wb_q.wreg;
  assign bus_err     = wb_q.err;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl (TIMEOUT=4). The stimulus task derives
// each instruction's expected WB slot (including the cycle it must appear in)
// and stall length from the handshake rules; a memory responder acks after a
// planned number of WAIT cycles and checks the request fields; a monitor pops
// and compares every wb_valid slot.
module tb_mem_stage_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  MEM_WB = '0, MEM_M = '0;
  logic [31:0] MEM_ALU_out = '0, DM_Wdata = '0, dm_rdata = '0;
  logic [4:0]  MEM_writeReg = '0;
  logic        stall, dm_req, dm_we, wb_valid, bus_err, dm_ack;
  logic [31:0] dm_addr, dm_wdata, WB_rdata, WB_alu;
  logic [1:0]  WB_ctrl;
  logic [4:0]  WB_writeReg;
  logic        resp_ack = 1'b0, spur_ack = 1'b0;

  assign dm_ack = resp_ack | spur_ack;

  mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .MEM_WB(MEM_WB), .MEM_M(MEM_M),
    .MEM_ALU_out(MEM_ALU_out), .DM_Wdata(DM_Wdata), .MEM_writeReg(MEM_writeReg),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_valid(wb_valid), .WB_ctrl(WB_ctrl), .WB_rdata(WB_rdata), .WB_alu(WB_alu),
    .WB_writeReg(WB_writeReg), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  ctrl;
    logic [31:0] alu, rdata;
    logic [4:0]  wreg;
    logic        err;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    int          d;
  } plan_t;

  wb_exp_t sbq[$];
  plan_t   planq[$];
  int checks = 0, failures = 0;

  task automatic chk(input bit ok, input string name, input string got, input string exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory model: ack after plan.d WAIT cycles (never, if the DUT times out first).
  plan_t cur;
  int    rcnt = 0;
  bit    active = 0;
  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (rst && dm_req) begin
      if (!active) begin
        if (planq.size() == 0) begin
          chk(0, "unexpected_dm_req", $sformatf("addr=%h", dm_addr), "no request");
          cur = '{we: dm_we, addr: dm_addr, wdata: dm_wdata, rdata: 32'h0, d: 1000};
        end else cur = planq.pop_front();
        active = 1;
        rcnt   = 0;
      end
      chk(dm_addr == cur.addr && dm_we == cur.we && dm_wdata == cur.wdata, "dm_cmd",
          $sformatf("we=%b addr=%h wdata=%h", dm_we, dm_addr, dm_wdata),
          $sformatf("we=%b addr=%h wdata=%h", cur.we, cur.addr, cur.wdata));
      if (rcnt == cur.d) begin
        resp_ack = 1'b1;
        dm_rdata = cur.rdata;
      end else dm_rdata = $urandom;
      rcnt++;
    end else active = 0;
  end

  // Monitor
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (sbq.size() == 0)
        chk(0, "unexpected_wb", $sformatf("cyc=%0d alu=%h", cyc, WB_alu), "no slot");
      else begin
        wb_exp_t e;
        e = sbq.pop_front();
        chk(cyc == e.cyc && WB_ctrl == e.ctrl && WB_alu == e.alu && WB_rdata == e.rdata &&
            WB_writeReg == e.wreg && bus_err == e.err, "wb_slot",
            $sformatf("cyc=%0d ctrl=%b alu=%h rdata=%h wr=%0d err=%b",
                      cyc, WB_ctrl, WB_alu, WB_rdata, WB_writeReg, bus_err),
            $sformatf("cyc=%0d ctrl=%b alu=%h rdata=%h wr=%0d err=%b",
                      e.cyc, e.ctrl, e.alu, e.rdata, e.wreg, e.err));
      end
    end
  end

  // Called at a negedge; holds the instruction while stall is high, returns at
  // the negedge after the instruction has been consumed.
  task automatic issue(input bit v, input logic [1:0] m, input logic [1:0] wb,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] wr, input int d, input logic [31:0] rd);
    bit      memop, mis;
    int      exp_st, n, c;
    wb_exp_t e;
    plan_t   p;
    memop = v && (m != 2'b00);
    mis   = 0;
`ifdef MEM_ALIGN_CHK_EN
    mis = memop && (addr[1:0] != 2'b00);
`endif
    c = cyc;
    e.alu = addr; e.wreg = wr; e.rdata = '0; e.err = 0; e.ctrl = wb;
    if (!memop || mis) begin
      exp_st = 0;
      if (mis) begin e.err = 1; e.ctrl[1] = 1'b0; end
    end else if (d >= TO) begin
      exp_st = TO;                       // issue cycle + TO-1 waiting cycles
      e.err = 1; e.ctrl[1] = 1'b0;
    end else begin
      exp_st = 1 + d;
      if (!m[0]) e.rdata = rd;
    end
    e.cyc = c + 1 + exp_st;
    if (v) sbq.push_back(e);
    if (memop && !mis) begin
      p = '{we: m[0], addr: addr, wdata: wd, rdata: rd, d: d};
      planq.push_back(p);
    end
    in_valid = v; MEM_M = m; MEM_WB = wb; MEM_ALU_out = addr; DM_Wdata = wd; MEM_writeReg = wr;
    #1;
    n = 0;
    while (stall && n < 50) begin @(negedge clk); #1; n++; end
    chk(n == exp_st, "stall_cycles", $sformatf("%0d", n), $sformatf("%0d", exp_st));
    @(negedge clk);
    if (!v) chk(!wb_valid && WB_ctrl == 2'b00, "invalid_bubble",
                $sformatf("wb_valid=%b ctrl=%b", wb_valid, WB_ctrl), "wb_valid=0 ctrl=00");
  endtask

  initial begin
    plan_t       p;
    bit          v;
    logic [1:0]  m, wb;
    logic [31:0] a;
    int          k;
    #7;
    chk(!stall && !dm_req && !dm_we && dm_addr == 0 && dm_wdata == 0 && !wb_valid &&
        WB_ctrl == 0 && WB_rdata == 0 && WB_alu == 0 && WB_writeReg == 0 && !bus_err,
        "reset_state", $sformatf("req=%b wbv=%b stall=%b", dm_req, wb_valid, stall), "all 0");
    @(negedge clk); rst = 1'b1;

    issue(1, 2'b00, 2'b10, 32'h10, 32'h0, 5'd5, 0, 32'h0);                 // ALU op
    issue(1, 2'b10, 2'b11, 32'h100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);        // load, 3 waits
    issue(1, 2'b01, 2'b00, 32'h200, 32'hCAFE_F00D, 5'd0, 0, 32'h1111_2222); // store
    issue(1, 2'b10, 2'b11, 32'h200, 32'h0, 5'd9, 0, 32'h1234_5678);        // load back-to-back
    issue(1, 2'b10, 2'b10, 32'h300, 32'h0, 5'd3, 99, 32'h0);               // timeout
    issue(1, 2'b11, 2'b11, 32'h304, 32'h77, 5'd4, 1, 32'hAAAA_AAAA);       // both set -> store
    issue(0, 2'b10, 2'b10, 32'h308, 32'h0, 5'd6, 0, 32'h0);                // empty slot
    issue(1, 2'b10, 2'b10, 32'h102, 32'h0, 5'd4, 1, 32'h55);               // misaligned load
    issue(1, 2'b10, 2'b11, 32'h30C, 32'h0, 5'd8, 3, 32'h0BAD_CAFE);        // ack on last cycle

    // Reset while waiting: everything drops without a clock edge.
    p = '{we: 1'b0, addr: 32'h400, wdata: 32'h0, rdata: 32'h0, d: 1000};
    planq.push_back(p);
    in_valid = 1; MEM_M = 2'b10; MEM_WB = 2'b11; MEM_ALU_out = 32'h400; DM_Wdata = 0; MEM_writeReg = 1;
    @(negedge clk); @(negedge clk);
    chk(dm_req && stall, "wait_before_reset", $sformatf("req=%b stall=%b", dm_req, stall), "1 1");
    #2 rst = 1'b0; in_valid = 1'b0;
    #1 chk(!dm_req && !wb_valid && !stall, "async_reset_abort",
           $sformatf("req=%b wbv=%b stall=%b", dm_req, wb_valid, stall), "0 0 0");
    @(negedge clk); rst = 1'b1;
    spur_ack = 1'b1;                                                        // spurious ack in IDLE
    @(negedge clk); spur_ack = 1'b0;
    chk(!dm_req && !wb_valid && !stall, "spurious_ack_ignored",
        $sformatf("req=%b wbv=%b stall=%b", dm_req, wb_valid, stall), "0 0 0");
    issue(1, 2'b00, 2'b10, 32'h44, 32'h0, 5'd2, 0, 32'h0);
    issue(1, 2'b10, 2'b11, 32'h48, 32'h0, 5'd3, 2, 32'h5A5A_A5A5);

    for (int i = 0; i < 150; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      m  = 2'($urandom);
      wb = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(v, m, wb, a, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
    end

    in_valid = 0;
    k = 0;
    while (sbq.size() != 0 && k < 20) begin @(negedge clk); k++; end
    chk(sbq.size() == 0 && planq.size() == 0, "drain",
        $sformatf("sb=%0d plan=%0d", sbq.size(), planq.size()), "0 0");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
